// File: rtl/design_24_sched_pkg.sv
// design_24_sched_pkg: shared FSM state encoding and id-width helper for the design_24 scheduler
package design_24_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/design_24_rr_arb.sv
// design_24_rr_arb: combinational round-robin picker searching upward from ptr with wrap
module design_24_rr_arb
  import design_24_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          found
);
  // Walk offsets downward so the nearest requester at or above ptr is written last.
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end
  assign win = found ? (N'(1) << idx) : '0;
endmodule

// File: rtl/design_24_sched.sv
// design_24_sched: round-robin front end issuing one transaction at a time to the design_24 datapath
module design_24_sched
  import design_24_sched_pkg::*;
#(
  parameter int W   = 20,
  parameter int N   = 4,
  parameter int TMO = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N*W-1:0]        a_in,
  input  logic [N*W-1:0]        b_in,
  output logic [N-1:0]          gnt,
  output logic                  dp_start,
  output logic [W-1:0]          dp_a,
  output logic [W-1:0]          dp_b,
  input  logic [W-1:0]          dp_y,
  input  logic                  dp_valid,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [clog2(N)-1:0]   rsp_id,
  output logic [W-1:0]          rsp_y,
  output logic                  rsp_err
);
  localparam int IW = clog2(N);
  state_e        state_q;
  logic [IW-1:0] ptr_q, ptr_d, id_q, win_idx;
  logic [7:0]    cnt_q;
  logic [N-1:0]  win;
  logic          found, dp_start_q, rsp_valid_q, rsp_err_q;
  logic [W-1:0]  dp_a_q, dp_b_q, rsp_y_q;
  design_24_rr_arb #(.N(N), .IW(IW)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .win   (win),
    .idx   (win_idx),
    .found (found)
  );
  assign ptr_d = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
  // Grant is a same-cycle acceptance, so it is also held off while reset is applied.
  assign gnt = (state_q == IDLE && rst_n) ? win : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      id_q <= '0;
      dp_start_q <= 1'b0;
      dp_a_q <= '0;
      dp_b_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          dp_a_q <= a_in[win_idx*W +: W];
          dp_b_q <= b_in[win_idx*W +: W];
          id_q <= win_idx;
          ptr_q <= ptr_d;
          dp_start_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          dp_start_q <= 1'b0;
          cnt_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (dp_valid || cnt_q == 8'(TMO - 1)) begin
            rsp_y_q <= dp_valid ? dp_y : '0;
            rsp_err_q <= !dp_valid;
            rsp_valid_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign dp_start  = dp_start_q;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_design_24_sched.sv
// tb_design_24_sched: randomized bench for design_24_sched against a behavioural round-robin model
module tb_design_24_sched;
  import design_24_sched_pkg::*;
  localparam int W = 20, N = 4, TMO = 15, IW = clog2(N);
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, gnt;
  logic [N*W-1:0] a_in = '0, b_in = '0;
  logic dp_start, dp_valid = 1'b0, rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [W-1:0] dp_a, dp_b, dp_y = '0, rsp_y;
  logic [IW-1:0] rsp_id;
  int n_chk = 0, n_fail = 0, m_ptr = 0;

  design_24_sched #(.W(W), .N(N), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_y(dp_y), .dp_valid(dp_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = W'($urandom);
      b_in[i*W +: W] = W'($urandom);
    end
  endtask

  // Runs one full transaction from IDLE and reports what it observed; dly<0 or >=TMO means no dp_valid.
  task automatic do_txn(input logic [N-1:0] rv, input int dly, input logic [W-1:0] yv, input int hold,
                        output logic [N-1:0] g, output int ng, output int ds, output logic [W-1:0] oa,
                        output logic [W-1:0] ob, output int lat, output logic [IW-1:0] id,
                        output logic [W-1:0] y, output logic err, output bit st);
    st = 1'b1; ng = 0; ds = 0; lat = -1;
    @(negedge clk); req = rv; rsp_ready = 1'b0; dp_valid = 1'b0; #1;
    g = gnt;
    if (gnt != 0) ng++;
    if (rsp_valid || dp_start) st = 1'b0;
    @(negedge clk);
    if (gnt != 0) ng++;
    if (dp_start) ds += 1;
    oa = dp_a; ob = dp_b;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = w; break; end
      if (gnt != 0) ng++;
      if (dp_start) ds += 10;
      if (dp_a !== oa || dp_b !== ob) st = 1'b0;
      dp_valid = (w == dly);
      dp_y = (w == dly) ? yv : W'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
    end
    dp_valid = 1'b0; rsp_ready = 1'b0;
    id = rsp_id; y = rsp_y; err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      dp_valid = 1'($urandom_range(0, 1));
      dp_y = W'($urandom);
      @(negedge clk);
      if (!rsp_valid || rsp_id !== id || rsp_y !== y || rsp_err !== err || gnt != 0 || dp_a !== oa) st = 1'b0;
    end
    dp_valid = 1'b0; rsp_ready = 1'b1; #1;
    if (gnt != 0 || !rsp_valid) st = 1'b0;
  endtask

  task automatic test_reset();
    req = '1; rsp_ready = 1'b1; dp_valid = 1'b1; dp_y = '1; a_in = '1; b_in = '1; rst_n = 1'b0;
    #12;
    n_chk++; if ({gnt, dp_start, dp_a, dp_b, rsp_valid, rsp_id, rsp_y, rsp_err} !== '0) begin n_fail++;
      $display("FAIL reset_outputs got gnt=%b st=%b a=%h b=%h v=%b id=%0d y=%h e=%b exp all 0", gnt, dp_start, dp_a, dp_b, rsp_valid, rsp_id, rsp_y, rsp_err); end
    @(negedge clk); req = '0; dp_valid = 1'b0; rst_n = 1'b1; m_ptr = 0;
    @(negedge clk); #1;
    n_chk++; if (gnt !== '0 || rsp_valid !== 1'b0 || dp_start !== 1'b0) begin n_fail++;
      $display("FAIL idle_no_req got gnt=%b v=%b st=%b exp 0 0 0", gnt, rsp_valid, dp_start); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g, eg; int ng, ds, lat, e; logic [W-1:0] oa, ob, y; logic [IW-1:0] id; logic err; bit st;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      e = pick(4'b1111, m_ptr); eg = N'(1) << e;
      do_txn(4'b1111, $urandom_range(0, 3), 20'h12345, 0, g, ng, ds, oa, ob, lat, id, y, err, st);
      n_chk++; if (g !== eg || id !== IW'(e)) begin n_fail++;
        $display("FAIL rr_order%0d got gnt=%b id=%0d exp gnt=%b id=%0d", i, g, id, eg, e); end
      n_chk++; if (ng !== 1) begin n_fail++; $display("FAIL rr_single_gnt%0d got %0d pulses exp 1", i, ng); end
      m_ptr = (e + 1) % N;
    end
  endtask

  task automatic test_single();
    logic [N-1:0] g; int ng, ds, lat; logic [W-1:0] oa, ob, y; logic [IW-1:0] id; logic err; bit st;
    a_in = '0; b_in = '0; a_in[0 +: W] = 20'd5; b_in[0 +: W] = 20'd7;
    do_txn(4'b0001, 0, 20'd12, 0, g, ng, ds, oa, ob, lat, id, y, err, st);
    n_chk++; if (g !== 4'b0001 || ng !== 1) begin n_fail++; $display("FAIL single_gnt got %b x%0d exp 0001 x1", g, ng); end
    n_chk++; if (ds !== 1) begin n_fail++; $display("FAIL single_dp_start got code %0d exp 1", ds); end
    n_chk++; if (oa !== 20'd5 || ob !== 20'd7) begin n_fail++; $display("FAIL single_ops got %0d/%0d exp 5/7", oa, ob); end
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL single_latency got %0d exp 1", lat); end
    n_chk++; if (id !== 0 || y !== 20'd12 || err !== 1'b0) begin n_fail++;
      $display("FAIL single_rsp got id=%0d y=%0d e=%b exp 0 12 0", id, y, err); end
    n_chk++; if (!st) begin n_fail++; $display("FAIL single_stable got 0 exp 1"); end
    m_ptr = 1;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g, eg; int ng, ds, lat, e; logic [W-1:0] oa, ob, y, yv; logic [IW-1:0] id; logic err; bit st;
    rand_ops();
    e = pick(4'b1111, m_ptr); eg = N'(1) << e; yv = W'($urandom);
    do_txn(4'b1111, 2, yv, 5, g, ng, ds, oa, ob, lat, id, y, err, st);
    n_chk++; if (g !== eg) begin n_fail++; $display("FAIL bp_gnt got %b exp %b", g, eg); end
    n_chk++; if (!st) begin n_fail++; $display("FAIL bp_hold got unstable exp stable"); end
    n_chk++; if (id !== IW'(e) || y !== yv || err !== 1'b0) begin n_fail++;
      $display("FAIL bp_rsp got id=%0d y=%h e=%b exp %0d %h 0", id, y, err, e, yv); end
    m_ptr = (e + 1) % N;
  endtask

  task automatic test_timeout();
    logic [N-1:0] g; int ng, ds, lat, e; logic [W-1:0] oa, ob, y; logic [IW-1:0] id; logic err; bit st;
    rand_ops();
    e = pick(4'b0010, m_ptr);
    do_txn(4'b0010, -1, 20'h0, 0, g, ng, ds, oa, ob, lat, id, y, err, st);
    n_chk++; if (lat !== TMO) begin n_fail++; $display("FAIL timeout_latency got %0d exp %0d", lat, TMO); end
    n_chk++; if (err !== 1'b1 || y !== '0 || id !== IW'(e)) begin n_fail++;
      $display("FAIL timeout_rsp got e=%b y=%h id=%0d exp 1 0 %0d", err, y, id, e); end
    m_ptr = (e + 1) % N;
  endtask

  task automatic test_collision();
    logic [N-1:0] g; int ng, ds, lat, e; logic [W-1:0] oa, ob, y; logic [IW-1:0] id; logic err; bit st;
    rand_ops();
    e = pick(4'b0100, m_ptr);
    do_txn(4'b0100, TMO - 1, 20'h00ABC, 0, g, ng, ds, oa, ob, lat, id, y, err, st);
    n_chk++; if (lat !== TMO) begin n_fail++; $display("FAIL collision_latency got %0d exp %0d", lat, TMO); end
    n_chk++; if (err !== 1'b0 || y !== 20'h00ABC) begin n_fail++;
      $display("FAIL collision_rsp got e=%b y=%h exp 0 00abc", err, y); end
    m_ptr = (e + 1) % N;
  endtask

  task automatic test_reset_mid_wait();
    logic [N-1:0] g; int ng, ds, lat, e; logic [W-1:0] oa, ob, y, yv; logic [IW-1:0] id; logic err; bit st, seen;
    rand_ops();
    do_txn(4'b0001, 0, 20'h1, 0, g, ng, ds, oa, ob, lat, id, y, err, st);
    m_ptr = 1;
    @(negedge clk); rsp_ready = 1'b0; req = 4'b0101; #1;
    e = pick(4'b0101, m_ptr);
    n_chk++; if (gnt !== N'(1) << e) begin n_fail++; $display("FAIL pre_reset_gnt got %b exp %b", gnt, N'(1) << e); end
    @(negedge clk); req = 4'b0001;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    n_chk++; if ({gnt, dp_start, dp_a, dp_b, rsp_valid, rsp_id, rsp_y, rsp_err} !== '0) begin n_fail++;
      $display("FAIL mid_reset_outputs got gnt=%b v=%b a=%h y=%h exp all 0", gnt, rsp_valid, dp_a, rsp_y); end
    @(negedge clk); req = '0; rst_n = 1'b1; m_ptr = 0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (rsp_valid || dp_start) seen = 1'b1; end
    n_chk++; if (seen) begin n_fail++; $display("FAIL dropped_txn got activity exp none"); end
    e = pick(4'b1001, m_ptr); yv = W'($urandom);
    do_txn(4'b1001, 1, yv, 0, g, ng, ds, oa, ob, lat, id, y, err, st);
    n_chk++; if (g !== N'(1) << e || id !== IW'(e) || y !== yv || lat !== 2) begin n_fail++;
      $display("FAIL post_reset_txn got gnt=%b id=%0d y=%h lat=%0d exp %b %0d %h 2", g, id, y, lat, N'(1) << e, e, yv); end
    m_ptr = (e + 1) % N;
  endtask

  task automatic test_random();
    logic [N-1:0] g, rv, eg; int ng, ds, lat, e, dly, hold, elat; logic [W-1:0] oa, ob, y, yv, ea, eb, ey;
    logic [IW-1:0] id; logic err, eerr; bit st;
    for (int i = 0; i < 40; i++) begin
      rand_ops();
      rv = N'($urandom_range(1, (1 << N) - 1));
      dly = $urandom_range(0, TMO + 2); hold = $urandom_range(0, 3);
      e = pick(rv, m_ptr); eg = N'(1) << e;
      ea = a_in[e*W +: W]; eb = b_in[e*W +: W]; yv = ea + eb;
      eerr = (dly >= TMO); elat = eerr ? TMO : dly + 1; ey = eerr ? '0 : yv;
      do_txn(rv, dly, yv, hold, g, ng, ds, oa, ob, lat, id, y, err, st);
      n_chk++; if (g !== eg || ng !== 1 || ds !== 1 || oa !== ea || ob !== eb) begin n_fail++;
        $display("FAIL rand%0d_issue got gnt=%b x%0d st=%0d a=%h b=%h exp %b x1 1 %h %h", i, g, ng, ds, oa, ob, eg, ea, eb); end
      n_chk++; if (lat !== elat || id !== IW'(e) || y !== ey || err !== eerr || !st) begin n_fail++;
        $display("FAIL rand%0d_rsp got lat=%0d id=%0d y=%h e=%b st=%b exp %0d %0d %h %b 1", i, lat, id, y, err, st, elat, e, ey, eerr); end
      m_ptr = (e + 1) % N;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_timeout();
    test_collision();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/design_24_sched.md
DESIGN_24_SCHED -- requirements
Module: design_24_sched

Interface
REQ-001 Parameter W, default 20: operand/result width; matches the design_24 datapath.
REQ-002 Parameter N, default 4: number of requesters; legal range 2..8.
REQ-003 Parameter TMO, default 15: maximum WAIT cycles before timeout; legal range 1..255.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req  in  N  per-requester request; requester holds it high until its gnt bit pulses.
REQ-007 a_in  in  N*W  operand A; requester i drives bits [i*W +: W].
REQ-008 b_in  in  N*W  operand B; same packing as a_in.
REQ-009 gnt  out  N  one-hot acceptance pulse, one cycle wide.
REQ-010 dp_start  out  1  start pulse to the datapath.
REQ-011 dp_a, dp_b  out  W each  operands to the datapath.
REQ-012 dp_y  in  W  datapath result.
REQ-013 dp_valid  in  1  datapath result-valid pulse.
REQ-014 rsp_valid  out  1  response valid.
REQ-015 rsp_ready  in  1  response consumer ready.
REQ-016 rsp_id  out  clog2(N)  index of the requester that owns the response.
REQ-017 rsp_y  out  W  result captured from dp_y.
REQ-018 rsp_err  out  1  timeout flag; qualified by rsp_valid.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP; at most one transaction is outstanding at any time.
REQ-020 IDLE, any req high: grant in round-robin order, searching upward from ptr with wrap from N-1 to 0.
- Same cycle: assert the winner's gnt bit, latch its a/b into dp_a/dp_b, latch its index, set ptr = winner+1 mod N.
- Next state: ISSUE.
REQ-021 IDLE, no req high: gnt=0; state and ptr unchanged.
REQ-022 ISSUE: dp_start=1 for exactly one cycle, then go to WAIT; dp_a/dp_b stay stable from grant until the RESP exit.
REQ-023 WAIT: an 8-bit counter starts at 0 on entry and increments each cycle.
- dp_valid=1: capture dp_y into rsp_y, rsp_err=0, go to RESP.
- Otherwise, counter==TMO-1: rsp_y=0, rsp_err=1, go to RESP.
REQ-024 dp_valid and the timeout in the same cycle: dp_valid wins and rsp_err=0.
REQ-025 dp_valid outside WAIT is ignored.
REQ-026 RESP: rsp_valid=1 and rsp_id/rsp_y/rsp_err stay stable until a cycle with rsp_ready=1; that cycle completes the handshake and returns to IDLE.
REQ-027 Arbitration is evaluated only in IDLE, so the earliest next grant is the cycle after the RESP handshake.
REQ-028 Minimum grant-to-response latency: 3 cycles (grant, ISSUE, one WAIT cycle with dp_valid, then rsp_valid).
REQ-029 rsp_ready while not in RESP has no effect.

Reset
REQ-030 rst_n low forces: state=IDLE, ptr=0, counter=0, gnt=0, dp_start=0, dp_a=dp_b=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_err=0.
REQ-031 Reset asserted mid-transaction drops that transaction without any response; after release the block restarts from IDLE with ptr=0.

Structure
REQ-032 A shared package holds the FSM state enumeration and the ID width function clog2(N).
REQ-033 One sub-module, design_24_rr_arb: combinational round-robin picker (req, ptr -> one-hot winner, index, found).
- The FSM, counter and registers live in design_24_sched.

Verification
REQ-034 Single request: req=0001, a=5, b=7, datapath returns 12 one cycle after dp_start -> gnt=0001 once, dp_start one cycle later, rsp_valid with id=0, y=12, err=0.
REQ-035 All requests held (req=1111), rsp_ready=1 throughout -> grant order 0,1,2,3,0 starting from ptr=0; no requester is granted twice while another is pending.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, id and y held constant; no new gnt until the handshake cycle.
REQ-037 Timeout: dp_valid never asserted, TMO=15 -> rsp_valid exactly 15 cycles after WAIT entry, with err=1 and y=0.
REQ-038 Collision: dp_valid pulsed on the WAIT cycle where counter==TMO-1 with dp_y=0x00ABC -> err=0, y=0x00ABC.
REQ-039 Reset mid-WAIT: rst_n pulsed low -> all outputs 0 immediately; the next grant is to the lowest-index active requester.
